msk_inv_pipe: RTL and testbench

Parametrised masked inversion/refresh pipeline for `count` independent d-share Boolean sharings. Per sharing, the block conditionally complements the encoded value by flipping share 0 only. It re-randomises the sharing with fresh randomness and carries the result through `LAT` elastic register stages with valid/ready handshakes. It replaces the purely combinational masked NOT wherever a registered, glitch-isolating, back-pressurable masked inverter is needed, for example between masked S-box layers and the state register.

---
 rtl/msk_inv_pipe.sv | 89 ++++++++
 tb/tb_msk_inv_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/msk_inv_pipe.sv
// Masked inversion/refresh pipeline: per-sharing share-0 complement plus optional
// re-randomisation, registered into LAT elastic valid/ready stages.
module msk_inv_pipe #(
    parameter int d       = 2,
    parameter int count   = 1,
    parameter int LAT     = 2,
    parameter int REFRESH = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [count*d-1:0]                      in,
    input  logic [count-1:0]                        inv,
    input  logic [((d > 1) ? count*(d-1) : 1)-1:0]  rnd,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [count*d-1:0]                      out,
    output logic                                    out_valid,
    input  logic                                    out_ready
);

    localparam int W  = count * d;
    localparam int RW = (d > 1) ? count * (d - 1) : 1;

    // Each random bit lands on share j and on share 0, so the encoded value is
    // preserved; the sharing is only touched here, directly in front of stage 0.
    function automatic logic [W-1:0] mask_xform(input logic [W-1:0]     din,
                                                input logic [count-1:0] inv_v,
                                                input logic [RW-1:0]    r);
        logic [W-1:0] res;
        logic         acc;
        res = din;
        for (int i = 0; i < count; i++) begin
            acc = inv_v[i];
            for (int j = 1; j < d; j++) begin
                if (REFRESH != 0) begin
                    res[i*d+j] = din[i*d+j] ^ r[i*(d-1)+j-1];
                    acc        = acc ^ r[i*(d-1)+j-1];
                end
            end
            res[i*d] = din[i*d] ^ acc;
        end
        return res;
    endfunction

    logic [W-1:0]   data_r [LAT];
    logic [LAT-1:0] v_r;
    logic [LAT-1:0] free_s;

    // A stage is free when the consumer pops or any stage from it to the tail holds a bubble.
    always_comb begin
        logic tail_full;
        tail_full = 1'b1;
        free_s    = '0;
        for (int k = LAT - 1; k >= 0; k--) begin
            tail_full = tail_full & v_r[k];
            free_s[k] = out_ready | ~tail_full;
        end
    end

    // Stage registers: valid flags follow the free chain, data loads only on valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r <= '0;
            for (int k = 0; k < LAT; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            if (free_s[0]) begin
                v_r[0] <= in_valid;
                if (in_valid) begin
                    data_r[0] <= mask_xform(in, inv, rnd);
                end
            end
            for (int k = 1; k < LAT; k++) begin
                if (free_s[k]) begin
                    v_r[k] <= v_r[k-1];
                    if (v_r[k-1]) begin
                        data_r[k] <= data_r[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = free_s[0];
    assign out       = data_r[LAT-1];
    assign out_valid = v_r[LAT-1];

endmodule

// File: tb/tb_msk_inv_pipe.sv
// Directed bench for msk_inv_pipe: reset, transform vectors, back-pressure,
// bubble collapse, mid-flight reset and a short randomised unmasked-value scoreboard.
module tb_msk_inv_pipe;

    logic clk;
    logic rst;

    // Instance A: d=2, count=2, LAT=2, REFRESH=1
    logic [3:0] in_a;
    logic [1:0] inv_a;
    logic [1:0] rnd_a;
    logic       in_valid_a;
    logic       in_ready_a;
    logic [3:0] out_a;
    logic       out_valid_a;
    logic       out_ready_a;

    // Instance B: d=3, count=1, LAT=2, REFRESH=0
    logic [2:0] in_b;
    logic [0:0] inv_b;
    logic [1:0] rnd_b;
    logic       in_valid_b;
    logic       in_ready_b;
    logic [2:0] out_b;
    logic       out_valid_b;
    logic       out_ready_b;

    int n_checks;
    int n_pass;

    logic [3:0] exp_q [$];
    logic [1:0] um_q  [$];

    msk_inv_pipe #(.d(2), .count(2), .LAT(2), .REFRESH(1)) u_a (
        .clk(clk), .rst(rst), .in(in_a), .inv(inv_a), .rnd(rnd_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out(out_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    msk_inv_pipe #(.d(3), .count(1), .LAT(2), .REFRESH(0)) u_b (
        .clk(clk), .rst(rst), .in(in_b), .inv(inv_b), .rnd(rnd_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out(out_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] unmask_a(input logic [3:0] v);
        return {v[3] ^ v[2], v[1] ^ v[0]};
    endfunction

    // One cycle on instance A: note whether a push happens, check any pop, then clock.
    task automatic step(input bit rand_mode, output bit pushed);
        logic [3:0] e;
        logic [1:0] u;
        #1;
        pushed = in_valid_a && in_ready_a;
        if (out_valid_a && out_ready_a) begin
            if (rand_mode) begin
                if (um_q.size() == 0) check("rand_pop_empty", 32'd1, 32'd0);
                else begin
                    u = um_q.pop_front();
                    check("rand_unmasked", {30'd0, unmask_a(out_a)}, {30'd0, u});
                end
            end else begin
                if (exp_q.size() == 0) check("pop_empty", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("pop_data", {28'd0, out_a}, {28'd0, e});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [3:0] items [4];
    logic [3:0] exps  [4];
    int         idx;
    bit         p;
    logic [1:0] um_in;

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        in_a        = 4'd0; inv_a = 2'd0; rnd_a = 2'd0;
        in_valid_a  = 1'b0; out_ready_a = 1'b1;
        in_b        = 3'd0; inv_b = 1'b0; rnd_b = 2'd0;
        in_valid_b  = 1'b0; out_ready_b = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_out", {28'd0, out_a}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Invert plus refresh on A, REFRESH=0 on B, same transfer edge
        in_a = 4'b0001; inv_a = 2'b01; rnd_a = 2'b11; in_valid_a = 1'b1;
        in_b = 3'b101;  inv_b = 1'b1;  rnd_b = 2'b11; in_valid_b = 1'b1;
        #1;
        check("inv_in_ready", {31'd0, in_ready_a}, 32'd1);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        check("lat_not_yet", {31'd0, out_valid_a}, 32'd0);
        in_b = 3'b011; inv_b = 1'b0; rnd_b = 2'b10; in_valid_b = 1'b1;
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        check("inv_out_valid", {31'd0, out_valid_a}, 32'd1);
        check("inv_out", {28'd0, out_a}, {28'd0, 4'b1111});
        check("inv_unmasked", {30'd0, unmask_a(out_a)}, {30'd0, 2'b00});
        check("norefresh_out", {29'd0, out_b}, {29'd0, 3'b100});
        check("norefresh_valid", {31'd0, out_valid_b}, 32'd1);
        @(posedge clk);
        #1;
        check("norefresh_out2", {29'd0, out_b}, {29'd0, 3'b011});
        repeat (2) @(posedge clk);
        #1;
        check("drained", {31'd0, out_valid_a}, 32'd0);

        // Back-pressure: inv=10, rnd=01 flips bits 0,1,2 of every item
        items[0] = 4'h0; items[1] = 4'h5; items[2] = 4'hA; items[3] = 4'hF;
        exps[0]  = 4'h7; exps[1]  = 4'h2; exps[2]  = 4'hD; exps[3]  = 4'h8;
        inv_a = 2'b10; rnd_a = 2'b01; out_ready_a = 1'b0; idx = 0;
        for (int i = 0; i < 4; i++) begin
            in_a = items[idx]; in_valid_a = 1'b1;
            step(1'b0, p);
            if (p) begin
                exp_q.push_back(exps[idx]);
                idx++;
            end
        end
        check("bp_accepted", idx, 32'd2);
        check("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
        check("bp_hold_valid", {31'd0, out_valid_a}, 32'd1);
        check("bp_hold_out", {28'd0, out_a}, {28'd0, 4'h7});
        in_a = items[idx];
        step(1'b0, p);
        check("bp_no_push", {31'd0, p}, 32'd0);
        check("bp_still_out", {28'd0, out_a}, {28'd0, 4'h7});
        out_ready_a = 1'b1;
        #1;
        check("full_pop_push", {31'd0, in_ready_a}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            if (idx >= 4 && exp_q.size() == 0) break;
            in_valid_a = (idx < 4);
            if (idx < 4) in_a = items[idx];
            step(1'b0, p);
            if (p) begin
                exp_q.push_back(exps[idx]);
                idx++;
            end
        end
        in_valid_a = 1'b0;
        check("bp_all_pushed", idx, 32'd4);
        check("bp_all_popped", exp_q.size(), 32'd0);

        // Bubble collapse: P parks in the last stage, Q fills the bubble
        out_ready_a = 1'b0; inv_a = 2'b00; rnd_a = 2'b00;
        in_a = 4'h3; in_valid_a = 1'b1;
        step(1'b0, p);
        if (p) exp_q.push_back(4'h3);
        check("bub_push_p", {31'd0, p}, 32'd1);
        in_valid_a = 1'b0;
        step(1'b0, p);
        check("bub_in_ready", {31'd0, in_ready_a}, 32'd1);
        in_a = 4'hC; in_valid_a = 1'b1;
        step(1'b0, p);
        if (p) exp_q.push_back(4'hC);
        check("bub_push_q", {31'd0, p}, 32'd1);
        in_valid_a = 1'b0;
        check("bub_full", {31'd0, in_ready_a}, 32'd0);
        out_ready_a = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) step(1'b0, p);
        check("bub_drained", exp_q.size(), 32'd0);

        // Mid-flight reset clears outputs without a clock edge
        out_ready_a = 1'b0;
        in_a = 4'h9; in_valid_a = 1'b1;
        step(1'b0, p);
        in_valid_a = 1'b0;
        step(1'b0, p);
        check("pre_rst_valid", {31'd0, out_valid_a}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid_a}, 32'd0);
        check("async_rst_out", {28'd0, out_a}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready_a}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        out_ready_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_emit_after_rst", {31'd0, out_valid_a}, 32'd0);

        // Randomised scoreboard on unmasked values
        for (int c = 0; c < 1500; c++) begin
            in_valid_a  = 1'($urandom_range(0, 1));
            out_ready_a = 1'($urandom_range(0, 1));
            in_a  = 4'($urandom_range(0, 15));
            inv_a = 2'($urandom_range(0, 3));
            rnd_a = 2'($urandom_range(0, 3));
            um_in = unmask_a(in_a) ^ inv_a;
            step(1'b1, p);
            if (p) um_q.push_back(um_in);
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        for (int c = 0; c < 10 && um_q.size() != 0; c++) step(1'b1, p);
        check("rand_drained", um_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
